fb_pixel_packer: RTL and testbench

Avalon-MM write initiator that feeds the 1-bpp VGA framebuffer peripheral. Accepts a raster-order stream of 1-bit pixels (640×480), packs 32 consecutive pixels into a word and issues one framebuffer write per word at the matching word address. It sits between a pixel producer (renderer/decoder) and the display's slave write port.

---
 rtl/fb_pixel_packer.sv | 181 ++++++++++++++++++
 tb/tb_fb_pixel_packer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_pixel_packer.sv
`default_nettype none
// ============================================================================
//  Module      : fb_pixel_packer
//  Description : Packs a raster-order stream of 1-bit pixels into 32-bit
//                words and issues one Avalon-MM write per word to the 1-bpp
//                VGA framebuffer, at the word address matching the pixels.
//                Pixel x of a word lands in bit x[4:0].
//  Ports       : clk, reset (sync, active-high)
//                pix_valid/pix_data/pix_sof/pix_ready : pixel stream in
//                clear_req                            : framebuffer clear request
//                avm_*                                : Avalon-MM write initiator
//                busy, frame_done, sof_err            : status
//  Options     : FB_CLEAR_EN - builds the CLEAR state that writes zeros
//                to the whole framebuffer on clear_req.
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_pixel_packer #(
    parameter int WORDS_PER_LINE = 20,
    parameter int LINES          = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_valid,
    input  logic        pix_data,
    input  logic        pix_sof,
    output logic        pix_ready,
    input  logic        clear_req,
    output logic [14:0] avm_address,
    output logic [31:0] avm_writedata,
    output logic        avm_write,
    output logic        avm_chipselect,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        frame_done,
    output logic        sof_err
);

    localparam int          c_LAST_INT  = WORDS_PER_LINE * LINES - 1;
    localparam logic [14:0] c_LAST_ADDR = 15'(c_LAST_INT);

    localparam logic [0:0]  c_ST_RUN    = 1'b0;
    localparam logic [0:0]  c_ST_CLEAR  = 1'b1;

    logic [0:0]  state_q,      state_d;
    logic [4:0]  bitcnt_q,     bitcnt_d;
    logic [30:0] acc_q,        acc_d;
    logic [14:0] wordaddr_q,   wordaddr_d;
    logic        out_valid_q,  out_valid_d;
    logic [31:0] wdata_q,      wdata_d;
    logic [14:0] addr_q,       addr_d;
    logic        frame_done_q, frame_done_d;
    logic        sof_err_q,    sof_err_d;
    logic        busy_q,       busy_d;

    logic        w_wr_acc;
    logic        w_pix_acc;
    logic [4:0]  w_eff_bit;
    logic [14:0] w_eff_addr;
    logic [31:0] w_acc_next;

    // Full accumulator with bit 31 stalled at 31 while the previous word
    // is still waiting for the slave.
    assign pix_ready = !reset && (state_q == c_ST_RUN) &&
                       !(out_valid_q && (bitcnt_q == 5'd31));

    assign w_wr_acc  = out_valid_q && !avm_waitrequest;
    assign w_pix_acc = pix_valid && pix_ready;

    // An SOF pixel is always pixel 0 of word 0, whatever the counters say.
    assign w_eff_bit  = pix_sof ? 5'd0  : bitcnt_q;
    assign w_eff_addr = pix_sof ? 15'd0 : wordaddr_q;

`ifndef FB_CLEAR_EN
    logic w_unused_clear_req;
    assign w_unused_clear_req = clear_req;
`endif

    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        acc_d        = acc_q;
        wordaddr_d   = wordaddr_q;
        out_valid_d  = out_valid_q;
        wdata_d      = wdata_q;
        addr_d       = addr_q;
        frame_done_d = 1'b0;
        sof_err_d    = 1'b0;

        w_acc_next            = {1'b0, acc_q};
        w_acc_next[w_eff_bit] = pix_data;

        if (w_wr_acc) begin
            out_valid_d  = 1'b0;
            frame_done_d = (addr_q == c_LAST_ADDR);
        end

        if (w_pix_acc) begin
            if (pix_sof && ((bitcnt_q != 5'd0) || (wordaddr_q != 15'd0))) begin
                sof_err_d = 1'b1;
            end
            if (w_eff_bit == 5'd31) begin
                // Hand-off; pix_ready guarantees the output register is free.
                out_valid_d = 1'b1;
                wdata_d     = w_acc_next;
                addr_d      = w_eff_addr;
                wordaddr_d  = (w_eff_addr == c_LAST_ADDR) ? 15'd0 : w_eff_addr + 15'd1;
                bitcnt_d    = 5'd0;
            end else begin
                acc_d       = w_acc_next[30:0];
                bitcnt_d    = w_eff_bit + 5'd1;
                wordaddr_d  = w_eff_addr;
            end
        end

`ifdef FB_CLEAR_EN
        if (state_q == c_ST_RUN) begin
            // Clear wins over a pixel accepted in the same cycle; that
            // pixel is dropped so the clear starts from a clean word.
            if (clear_req && (bitcnt_q == 5'd0) && !out_valid_q) begin
                state_d     = c_ST_CLEAR;
                out_valid_d = 1'b1;
                wdata_d     = 32'd0;
                addr_d      = 15'd0;
                wordaddr_d  = 15'd0;
                bitcnt_d    = 5'd0;
                acc_d       = acc_q;
                sof_err_d   = 1'b0;
            end
        end else begin
            // The output address register doubles as the clear counter.
            if (w_wr_acc) begin
                if (addr_q == c_LAST_ADDR) begin
                    state_d     = c_ST_RUN;
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = 1'b1;
                    addr_d      = addr_q + 15'd1;
                end
            end
        end
`endif

        busy_d = out_valid_d || (state_d == c_ST_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= c_ST_RUN;
            bitcnt_q     <= 5'd0;
            acc_q        <= 31'd0;
            wordaddr_q   <= 15'd0;
            out_valid_q  <= 1'b0;
            wdata_q      <= 32'd0;
            addr_q       <= 15'd0;
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            acc_q        <= acc_d;
            wordaddr_q   <= wordaddr_d;
            out_valid_q  <= out_valid_d;
            wdata_q      <= wdata_d;
            addr_q       <= addr_d;
            frame_done_q <= frame_done_d;
            sof_err_q    <= sof_err_d;
            busy_q       <= busy_d;
        end
    end

    assign avm_write      = out_valid_q;
    assign avm_chipselect = out_valid_q;
    assign avm_address    = addr_q;
    assign avm_writedata  = wdata_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;
    assign sof_err        = sof_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_pixel_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fb_pixel_packer
//  Description : Directed self-checking bench for fb_pixel_packer, run on a
//                reduced 20x4-word frame (2560 pixels, last address 79).
//                The clear sequence is exercised when FB_CLEAR_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_pixel_packer;

    localparam int c_WPL  = 20;
    localparam int c_LN   = 4;
    localparam int c_PIX  = c_WPL * c_LN * 32;
    localparam int c_LAST = c_WPL * c_LN - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_valid, pix_data, pix_sof, pix_ready;
    logic        clear_req;
    logic [14:0] avm_address;
    logic [31:0] avm_writedata;
    logic        avm_write, avm_chipselect, avm_waitrequest;
    logic        busy, frame_done, sof_err;

    int checks   = 0;
    int failures = 0;

    // Write log collected by the monitor.
    int          wr_addr[$];
    logic [31:0] wr_data[$];
    int          fd_cnt    = 0;
    int          fd_last   = -1;
    int          sof_cnt   = 0;
    int          wr_cycles = 0;

    fb_pixel_packer #(.WORDS_PER_LINE(c_WPL), .LINES(c_LN)) dut (
        .clk(clk), .reset(reset),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_sof(pix_sof),
        .pix_ready(pix_ready), .clear_req(clear_req),
        .avm_address(avm_address), .avm_writedata(avm_writedata),
        .avm_write(avm_write), .avm_chipselect(avm_chipselect),
        .avm_waitrequest(avm_waitrequest),
        .busy(busy), .frame_done(frame_done), .sof_err(sof_err)
    );

    always #5 clk = ~clk;

    // Inputs change at posedge+1; outputs are sampled on the falling edge.
    always @(negedge clk) begin
        if (avm_write) wr_cycles++;
        if (avm_write && !avm_waitrequest) begin
            wr_addr.push_back(int'(avm_address));
            wr_data.push_back(avm_writedata);
        end
        if (frame_done) begin
            fd_cnt++;
            fd_last = (wr_addr.size() > 0) ? wr_addr[wr_addr.size()-1] : -1;
        end
        if (sof_err) sof_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
    endtask

    // Present one pixel and hold it until accepted; returns at posedge+1.
    task automatic send(input logic d, input logic s);
        int n;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_sof   = s;
        n = 0;
        @(negedge clk);
        while (!pix_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("send_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    initial begin
        int s, bad, fd0, sc0, wc0, n;
        reset = 1'b1; pix_valid = 1'b0; pix_data = 1'b0; pix_sof = 1'b0;
        clear_req = 1'b0; avm_waitrequest = 1'b0;

        // ---- reset defaults ----
        @(negedge clk);
        chk("rst_write",  32'(avm_write), 32'd0);
        chk("rst_cs",     32'(avm_chipselect), 32'd0);
        chk("rst_addr",   32'(avm_address), 32'd0);
        chk("rst_data",   avm_writedata, 32'd0);
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_fd",     32'(frame_done), 32'd0);
        chk("rst_soferr", 32'(sof_err), 32'd0);
        chk("rst_ready",  32'(pix_ready), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(pix_ready), 32'd1);
        @(posedge clk); #1;

        // ---- full frame, pixel = x[0] ----
        s = wr_addr.size(); fd0 = fd_cnt; wc0 = wr_cycles; sc0 = sof_cnt;
        for (int i = 0; i < c_PIX; i++) begin
            send(i[0], i == 0);
            if (i == 30) chk("lat_pre_write", 32'(avm_write), 32'd0);
            if (i == 31) begin
                chk("lat_write", 32'(avm_write), 32'd1);
                chk("lat_cs",    32'(avm_chipselect), 32'd1);
                chk("lat_addr",  32'(avm_address), 32'd0);
            end
        end
        cyc(4);
        chk("ff_count", 32'(wr_addr.size() - s), 32'(c_LAST + 1));
        bad = 0;
        for (int k = 0; k < c_LAST + 1; k++)
            if (wr_addr[s+k] != k || wr_data[s+k] !== 32'hAAAAAAAA) bad++;
        chk("ff_addr_data", 32'(bad), 32'd0);
        chk("ff_wr_cycles", 32'(wr_cycles - wc0), 32'(c_LAST + 1));
        chk("ff_fd_count",  32'(fd_cnt - fd0), 32'd1);
        chk("ff_fd_after",  32'(fd_last), 32'(c_LAST));
        chk("ff_no_soferr", 32'(sof_cnt - sc0), 32'd0);

        // ---- bit order: only x=37 on line 2 is white ----
        s = wr_addr.size();
        for (int i = 0; i < c_PIX; i++)
            send((i / 640 == 2) && (i % 640 == 37), i == 0);
        cyc(4);
        chk("bo_count", 32'(wr_addr.size() - s), 32'(c_LAST + 1));
        chk("bo_addr41_addr", 32'(wr_addr[s+41]), 32'd41);
        chk("bo_addr41_data", wr_data[s+41], 32'h00000020);
        bad = 0;
        for (int k = 0; k < c_LAST + 1; k++)
            if (k != 41 && wr_data[s+k] !== 32'd0) bad++;
        chk("bo_others_zero", 32'(bad), 32'd0);

        // ---- back-pressure: pixel k = (k%3==0) ----
        s = wr_addr.size();
        avm_waitrequest = 1'b1;
        for (int k = 0; k < 32; k++) send(k % 3 == 0, k == 0);
        for (int k = 32; k < 63; k++) begin
            send(k % 3 == 0, 1'b0);
            chk("bp_hold_addr", 32'(avm_address), 32'd0);
            chk("bp_hold_data", avm_writedata, 32'h49249249);
        end
        pix_valid = 1'b1; pix_data = 1'b1;
        chk("bp_ready_drop", 32'(pix_ready), 32'd0);
        for (int k = 0; k < 9; k++) begin
            cyc(1);
            chk("bp_wait_write", 32'(avm_write), 32'd1);
            chk("bp_wait_addr",  32'(avm_address), 32'd0);
            chk("bp_wait_data",  avm_writedata, 32'h49249249);
            chk("bp_wait_ready", 32'(pix_ready), 32'd0);
        end
        avm_waitrequest = 1'b0;
        send(1'b1, 1'b0);
        chk("bp_next_addr", 32'(avm_address), 32'd1);
        chk("bp_next_data", avm_writedata, 32'h92492492);
        cyc(3);
        chk("bp_count", 32'(wr_addr.size() - s), 32'd2);
        chk("bp_w0_addr", 32'(wr_addr[s]),   32'd0);
        chk("bp_w0_data", wr_data[s],        32'h49249249);
        chk("bp_w1_addr", 32'(wr_addr[s+1]), 32'd1);
        chk("bp_w1_data", wr_data[s+1],      32'h92492492);

        // ---- misaligned SOF after 45 white pixels ----
        do_reset();
        s = wr_addr.size(); sc0 = sof_cnt;
        for (int k = 0; k < 45; k++) send(1'b1, k == 0);
        send(1'b1, 1'b1);
        chk("sof_err_pulse", 32'(sof_err), 32'd1);
        cyc(1);
        chk("sof_err_clear", 32'(sof_err), 32'd0);
        for (int k = 1; k < 32; k++) send(k % 2 == 0, 1'b0);
        cyc(3);
        chk("sof_count",    32'(wr_addr.size() - s), 32'd2);
        chk("sof_w0_addr",  32'(wr_addr[s]),   32'd0);
        chk("sof_w0_data",  wr_data[s],        32'hFFFFFFFF);
        chk("sof_w1_addr",  32'(wr_addr[s+1]), 32'd0);
        chk("sof_w1_data",  wr_data[s+1],      32'h55555555);
        chk("sof_err_once", 32'(sof_cnt - sc0), 32'd1);

`ifdef FB_CLEAR_EN
        // ---- clear from idle ----
        s = wr_addr.size(); fd0 = fd_cnt;
        clear_req = 1'b1;
        cyc(1);
        clear_req = 1'b0;
        chk("clr_busy",  32'(busy), 32'd1);
        chk("clr_ready", 32'(pix_ready), 32'd0);
        chk("clr_write", 32'(avm_write), 32'd1);
        chk("clr_addr0", 32'(avm_address), 32'd0);
        n = 0;
        bad = 0;
        while (!frame_done && n < 300) begin
            if (busy !== 1'b1 || pix_ready !== 1'b0) bad++;
            cyc(1);
            n++;
        end
        chk("clr_done_seen", 32'(frame_done), 32'd1);
        chk("clr_busy_hold", 32'(bad), 32'd0);
        cyc(1);
        chk("clr_count", 32'(wr_addr.size() - s), 32'(c_LAST + 1));
        bad = 0;
        for (int k = 0; k < c_LAST + 1; k++)
            if (wr_addr[s+k] != k || wr_data[s+k] !== 32'd0) bad++;
        chk("clr_addr_data", 32'(bad), 32'd0);
        chk("clr_fd_count", 32'(fd_cnt - fd0), 32'd1);
        chk("clr_run_ready", 32'(pix_ready), 32'd1);
        chk("clr_run_busy",  32'(busy), 32'd0);

        // ---- clear request while a write is pending is ignored ----
        s = wr_addr.size();
        avm_waitrequest = 1'b1;
        for (int k = 0; k < 32; k++) send(1'b1, 1'b0);
        clear_req = 1'b1;
        cyc(1);
        clear_req = 1'b0;
        avm_waitrequest = 1'b0;
        cyc(4);
        chk("clr_ign_count", 32'(wr_addr.size() - s), 32'd1);
        chk("clr_ign_addr",  32'(wr_addr[s]), 32'd0);
        chk("clr_ign_data",  wr_data[s], 32'hFFFFFFFF);
        chk("clr_ign_busy",  32'(busy), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
